// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath strobes and the ALU op.
// Latency: R-type/ADDI/SW 4, LW 5, BEQ 3, J 2 cycles with zero-wait memory; each memory wait cycle adds one.
// Backpressure: mem_rd/mem_wr and the address select are held steady until mem_ready; mem_ready is ignored elsewhere.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   opcode, funct          IR[15:12] and IR[3:0]; opcode is stable from DECODE until the next fetch completes
//   zero                   ALU zero flag, consumed by BEQ in EXEC
//   mem_ready              memory completes the current read/write this cycle
//   mem_rd, mem_wr, iord   memory strobes and address select (0 = PC, 1 = ALUOut)
//   ir_we, pc_we, reg_we   register write enables
//   pc_src                 00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a, alu_src_b   ALU operand selects
//   alu_op                 4-bit ALU function code
//   reg_dst, mem_to_reg    writeback destination / data selects
//   illegal                one-cycle pulse in DECODE on an undefined opcode
//   halted                 high in HALT
//   retired                count of completed instructions (wraps)

module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [3:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    // ALU function codes used by the controller itself.
    localparam logic [3:0] FUNCT_ADD = 4'h0;
    localparam logic [3:0] FUNCT_SUB = 4'h1;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_J     = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state;
    logic   op_legal;
    logic   retire;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_legal = 1'b1;
            default:                                                op_legal = 1'b0;
        endcase
    end

    // An instruction retires on the cycle its last architectural update happens.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE: retire = (opcode == OP_J);
            S_EXEC:   retire = (opcode == OP_BEQ);
            S_MEM:    retire = (opcode == OP_SW) && mem_ready;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state <= S_HALT;
                    end else if (opcode == OP_J || !op_legal) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: state <= S_WB;
                        OP_LW, OP_SW:      state <= S_MEM;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (opcode == OP_SW) ? S_FETCH : S_WB;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from state plus inputs so that the fetch/MEM handshake and
    // the branch enable react in the same cycle mem_ready / zero arrive.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = FUNCT_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                if (opcode == OP_J) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                end
                illegal = !op_legal;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_b = 2'b00;
                        alu_op    = funct;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_b = 2'b10;
                    end
                    OP_BEQ: begin
                        alu_src_b = 2'b00;
                        alu_op    = FUNCT_SUB;
                        pc_src    = 2'b01;
                        pc_we     = zero;
                    end
                    default: begin
                        alu_src_b = 2'b00;
                    end
                endcase
            end
            S_MEM: begin
                iord   = 1'b1;
                mem_rd = (opcode == OP_LW);
                mem_wr = (opcode == OP_SW);
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase

        // Reset forces strobes low without waiting for a clock.
        if (!rst_n) begin
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance share all stimulus; outputs are sampled 1-2 time units after the rising edge.
module tb_multicycle_ctrl;

    localparam logic [3:0] FUNCT_ADD = 4'h0;
    localparam logic [3:0] FUNCT_SUB = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_rd, mem_wr, iord, ir_we, pc_we, reg_we;
    logic [1:0]  pc_src, alu_src_b;
    logic        alu_src_a, reg_dst, mem_to_reg, illegal, halted;
    logic [3:0]  alu_op;
    logic [15:0] retired;

    logic        n_mem_rd, n_mem_wr, n_iord, n_ir_we, n_pc_we, n_reg_we;
    logic [1:0]  n_pc_src, n_alu_src_b;
    logic        n_alu_src_a, n_reg_dst, n_mem_to_reg, n_illegal, n_halted;
    logic [3:0]  n_alu_op;
    logic [3:0]  n_retired;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .halted(halted), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(n_mem_rd), .mem_wr(n_mem_wr), .iord(n_iord),
        .ir_we(n_ir_we), .pc_we(n_pc_we), .reg_we(n_reg_we), .pc_src(n_pc_src),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .illegal(n_illegal),
        .halted(n_halted), .retired(n_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int c0;
        int irw;
        int unsteady;
        int stray;

        rst_n     = 1'b0;
        opcode    = 4'd0;
        funct     = 4'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_retired", 32'(retired), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // SW interrupted by reset while waiting in MEM
        opcode    = 4'd3;
        mem_ready = 1'b1;
        #1;
        chk("sw_fetch_rd", 32'(mem_rd), 1);
        chk("sw_fetch_irwe", 32'(ir_we), 1);
        tick();
        mem_ready = 1'b0;
        tick();
        #1;
        chk("sw_exec_srcb", 32'(alu_src_b), 2);
        chk("sw_exec_srca", 32'(alu_src_a), 1);
        tick();
        #1;
        chk("sw_mem_wr", 32'(mem_wr), 1);
        chk("sw_mem_iord", 32'(iord), 1);
        chk("sw_mem_rd", 32'(mem_rd), 0);
        tick();
        chk("sw_wait_wr", 32'(mem_wr), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_async", 32'(mem_wr), 0);
        chk("midrst_state", 32'(dut.state), 0);
        chk("midrst_retired", 32'(retired), 0);
        tick();
        rst_n = 1'b1;

        // R-type SUB, zero-wait
        opcode    = 4'd0;
        funct     = FUNCT_SUB;
        mem_ready = 1'b1;
        c0        = cyc;
        #1;
        chk("r_st_f", 32'(dut.state), 0);
        chk("r_pcwe_f", 32'(pc_we), 1);
        tick();
        chk("r_st_d", 32'(dut.state), 1);
        chk("r_srcb_d", 32'(alu_src_b), 3);
        chk("r_op_d", 32'(alu_op), 32'(FUNCT_ADD));
        tick();
        chk("r_st_e", 32'(dut.state), 2);
        chk("r_op_e", 32'(alu_op), 32'(FUNCT_SUB));
        chk("r_srcb_e", 32'(alu_src_b), 0);
        tick();
        chk("r_st_wb", 32'(dut.state), 4);
        chk("r_regwe", 32'(reg_we), 1);
        chk("r_regdst", 32'(reg_dst), 1);
        chk("r_memtoreg", 32'(mem_to_reg), 0);
        chk("r_ret_before", 32'(retired), 0);
        tick();
        chk("r_st_back", 32'(dut.state), 0);
        chk("r_retired", 32'(retired), 1);
        chk("r_latency", 32'(cyc - c0), 4);

        // LW: 2 wait cycles in FETCH, 3 in MEM
        opcode    = 4'd2;
        mem_ready = 1'b0;
        c0        = cyc;
        irw       = 0;
        unsteady  = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!(mem_rd === 1'b1 && iord === 1'b0)) unsteady++;
            if (ir_we === 1'b1) irw++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (!(mem_rd === 1'b1 && iord === 1'b0)) unsteady++;
        if (ir_we === 1'b1) irw++;
        tick();
        mem_ready = 1'b0;
        if (ir_we === 1'b1) irw++;
        tick();
        if (ir_we === 1'b1) irw++;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (!(mem_rd === 1'b1 && iord === 1'b1 && dut.state == 3'd3)) unsteady++;
            if (ir_we === 1'b1) irw++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (!(mem_rd === 1'b1 && iord === 1'b1)) unsteady++;
        tick();
        mem_ready = 1'b0;
        chk("lw_st_wb", 32'(dut.state), 4);
        chk("lw_memtoreg", 32'(mem_to_reg), 1);
        chk("lw_regdst", 32'(reg_dst), 0);
        tick();
        chk("lw_irwe_pulses", 32'(irw), 1);
        chk("lw_strobe_steady", 32'(unsteady), 0);
        chk("lw_latency", 32'(cyc - c0), 10);
        chk("lw_retired", 32'(retired), 2);

        // BEQ taken
        opcode    = 4'd4;
        mem_ready = 1'b1;
        c0        = cyc;
        tick();
        tick();
        zero = 1'b1;
        #1;
        chk("beq1_pcwe", 32'(pc_we), 1);
        chk("beq1_pcsrc", 32'(pc_src), 1);
        chk("beq1_op", 32'(alu_op), 32'(FUNCT_SUB));
        zero = 1'b0;
        #1;
        chk("beq_zero_follow", 32'(pc_we), 0);
        zero = 1'b1;
        tick();
        chk("beq1_latency", 32'(cyc - c0), 3);
        chk("beq1_retired", 32'(retired), 3);

        // BEQ not taken
        zero = 1'b0;
        c0   = cyc;
        tick();
        tick();
        chk("beq0_pcwe", 32'(pc_we), 0);
        chk("beq0_st", 32'(dut.state), 2);
        tick();
        chk("beq0_st_back", 32'(dut.state), 0);
        chk("beq0_latency", 32'(cyc - c0), 3);
        chk("beq0_retired", 32'(retired), 4);

        // Illegal opcode
        opcode = 4'd7;
        tick();
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_pcwe", 32'(pc_we), 0);
        tick();
        chk("ill_drop", 32'(illegal), 0);
        chk("ill_st", 32'(dut.state), 0);
        chk("ill_retired", 32'(retired), 4);

        // Jump
        opcode = 4'd5;
        c0     = cyc;
        tick();
        chk("j_pcwe", 32'(pc_we), 1);
        chk("j_pcsrc", 32'(pc_src), 2);
        tick();
        chk("j_latency", 32'(cyc - c0), 2);
        chk("j_retired", 32'(retired), 5);
        chk("n_retired5", 32'(n_retired), 5);

        // Halt holds for 100 cycles with no strobes
        opcode = 4'd15;
        tick();
        tick();
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            #1;
            if (mem_rd | mem_wr | ir_we | pc_we | reg_we | illegal | !halted) stray++;
            tick();
        end
        chk("halt_st", 32'(dut.state), 5);
        chk("halt_quiet", 32'(stray), 0);
        chk("halt_retired", 32'(retired), 5);

        // Counter wrap on the 4-bit instance
        rst_n = 1'b0;
        #1;
        chk("wrap_rst_n_retired", 32'(n_retired), 0);
        tick();
        rst_n     = 1'b1;
        opcode    = 4'd5;
        mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            tick();
            if (i == 14) chk("wrap_at15", 32'(n_retired), 15);
            if (i == 15) chk("wrap_to0", 32'(n_retired), 0);
        end
        chk("wrap_wide", 32'(retired), 17);
        chk("wrap_narrow", 32'(n_retired), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
